// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: multi-stage operand forwarding, store-data forwarding,
// load-use stall detection and a per-register scoreboard for variable-latency
// long ops (mul/div) with an outstanding-op limit and a stall-cycle counter.
module hazard_scoreboard #(
    parameter int FWD_STAGES      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEL_W           = $clog2(FWD_STAGES + 1),
    parameter int CNT_W           = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [4:0]                           ex_rs1,
    input  logic [4:0]                           ex_rs2,
    input  logic [FWD_STAGES-1:0]                stage_wen,
    input  logic [5*FWD_STAGES-1:0]              stage_rd,
    input  logic                                 me_mem_write_ena,
    input  logic [4:0]                           me_rs2,
    input  logic                                 id_valid,
    input  logic [4:0]                           id_rs1,
    input  logic [4:0]                           id_rs2,
    input  logic [4:0]                           id_rd,
    input  logic                                 id_rs1_used,
    input  logic                                 id_rs2_used,
    input  logic                                 id_rd_used,
    input  logic                                 ex_valid,
    input  logic                                 ex_mem_read,
    input  logic [4:0]                           ex_rd,
    input  logic                                 lop_issue,
    input  logic [4:0]                           lop_issue_rd,
    input  logic                                 lop_done,
    input  logic [4:0]                           lop_done_rd,
    output logic [SEL_W-1:0]                     forwardA,
    output logic [SEL_W-1:0]                     forwardB,
    output logic                                 forwardB_st,
    output logic                                 stall_id,
    output logic                                 lop_full,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic [CNT_W-1:0]                     stall_cycles,
    output logic                                 sb_err
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUTSTANDING);

    logic [31:0]      pending_q, pending_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic [SEL_W-1:0] fwd_a, fwd_b;
    logic             full, lu, sb, stall;
    logic             issue_ok, done_ok, err_now;

    // Forward selects: scan oldest to youngest so the youngest match is the last write.
    // NOTE: inside always_comb every variable gets a default first and uses blocking
    // assignments, so the block is pure logic and no latch is inferred.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stage_wen[k] && stage_rd[5*k +: 5] != 5'd0 && stage_rd[5*k +: 5] == ex_rs1)
                fwd_a = SEL_W'(k + 1);
            if (stage_wen[k] && stage_rd[5*k +: 5] != 5'd0 && stage_rd[5*k +: 5] == ex_rs2)
                fwd_b = SEL_W'(k + 1);
        end
    end

    assign full = (out_q == MAX_CNT);

    assign lu = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));

    // pending_q[0] is never set, so x0 never raises a scoreboard hazard.
    assign sb = id_valid && ((id_rs1_used && pending_q[id_rs1]) ||
                             (id_rs2_used && pending_q[id_rs2]) ||
                             (id_rd_used  && pending_q[id_rd]));

    assign stall = !rst && (lu || sb || full);

    // A simultaneous done frees a slot, so an issue at capacity is accepted then.
    assign issue_ok = lop_issue && (!full || (lop_done && out_q != '0));
    assign done_ok  = lop_done && (out_q != '0);
    assign err_now  = (lop_issue && full && !lop_done) ||
                      (lop_done && out_q == '0) ||
                      (lop_done && lop_done_rd != 5'd0 && !pending_q[lop_done_rd]);

    // Next-state for pending bits and the outstanding count; set beats clear on the same rd.
    always_comb begin
        pending_d = pending_q;
        if (done_ok)
            pending_d[lop_done_rd] = 1'b0;
        if (issue_ok && lop_issue_rd != 5'd0)
            pending_d[lop_issue_rd] = 1'b1;
        case ({issue_ok, done_ok})
            2'b10:   out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase
    end

    // Scoreboard state, saturating stall counter and sticky error flag.
    // NOTE: the 32 pending bits are ordinary flops, so they are cleared by reset
    // like the rest of the state; a mid-flight reset must discard every hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            out_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            if (stall && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            if (err_now)
                err_q <= 1'b1;
        end
    end

    // NOTE: outputs are gated by rst directly, so they read 0 from the moment rst
    // rises, before the first reset edge has cleared the registers.
    assign forwardA     = rst ? '0 : fwd_a;
    assign forwardB     = rst ? '0 : fwd_b;
    assign forwardB_st  = !rst && me_mem_write_ena && (me_rs2 != 5'd0) && (me_rs2 == ex_rs2);
    assign stall_id     = stall;
    assign lop_full     = !rst && full;
    assign outstanding  = rst ? '0 : out_q;
    assign stall_cycles = rst ? '0 : cnt_q;
    assign sb_err       = !rst && err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (FWD_STAGES=2, MAX_OUTSTANDING=4).
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_rs1, ex_rs2;
    logic [1:0]  stage_wen;
    logic [9:0]  stage_rd;
    logic        me_mem_write_ena;
    logic [4:0]  me_rs2;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_used;
    logic        ex_valid, ex_mem_read;
    logic [4:0]  ex_rd;
    logic        lop_issue;
    logic [4:0]  lop_issue_rd;
    logic        lop_done;
    logic [4:0]  lop_done_rd;
    logic [1:0]  forwardA, forwardB;
    logic        forwardB_st, stall_id, lop_full;
    logic [2:0]  outstanding;
    logic [31:0] stall_cycles;
    logic        sb_err;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(.FWD_STAGES(2), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .stage_wen(stage_wen), .stage_rd(stage_rd),
        .me_mem_write_ena(me_mem_write_ena), .me_rs2(me_rs2),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_used(id_rd_used),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .lop_issue(lop_issue), .lop_issue_rd(lop_issue_rd),
        .lop_done(lop_done), .lop_done_rd(lop_done_rd),
        .forwardA(forwardA), .forwardB(forwardB), .forwardB_st(forwardB_st),
        .stall_id(stall_id), .lop_full(lop_full), .outstanding(outstanding),
        .stall_cycles(stall_cycles), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ex_rs1 = 5'd3; ex_rs2 = 5'd0; stage_wen = 2'b11; stage_rd = {5'd3, 5'd3};
        me_mem_write_ena = 1'b0; me_rs2 = 5'd0;
        id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_used = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        lop_issue = 1'b0; lop_issue_rd = 5'd0; lop_done = 1'b0; lop_done_rd = 5'd0;

        // Reset: outputs forced low even with a forwarding match present.
        #2;
        check("rst_fwdA_comb", 32'(forwardA), 32'd0);
        tick();
        tick();
        check("rst_outstanding", 32'(outstanding), 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_sb_err", 32'(sb_err), 32'd0);
        check("rst_stall_id", 32'(stall_id), 32'd0);
        rst = 1'b0;
        #1;

        // Forward priority.
        check("fwdA_both_match", 32'(forwardA), 32'd1);
        stage_rd = {5'd3, 5'd0}; #1;
        check("fwdA_stage0_x0", 32'(forwardA), 32'd2);
        stage_wen = 2'b10; stage_rd = {5'd3, 5'd3}; #1;
        check("fwdA_only_wb", 32'(forwardA), 32'd2);
        stage_wen = 2'b00; #1;
        check("fwdA_no_wen", 32'(forwardA), 32'd0);
        stage_wen = 2'b11; stage_rd = 10'd0; ex_rs1 = 5'd0; #1;
        check("fwdA_x0", 32'(forwardA), 32'd0);
        stage_rd = {5'd9, 5'd4}; ex_rs2 = 5'd9; #1;
        check("fwdB_wb", 32'(forwardB), 32'd2);
        me_mem_write_ena = 1'b1; me_rs2 = 5'd9; #1;
        check("fwdB_st_hit", 32'(forwardB_st), 32'd1);
        me_rs2 = 5'd0; ex_rs2 = 5'd0; #1;
        check("fwdB_st_x0", 32'(forwardB_st), 32'd0);
        me_mem_write_ena = 1'b0; stage_wen = 2'b00; stage_rd = 10'd0;

        // Load-use: one stalled cycle counted.
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_rs2 = 5'd5; id_rs2_used = 1'b1; #1;
        check("lu_stall", 32'(stall_id), 32'd1);
        tick();
        check("lu_count", stall_cycles, 32'd1);
        id_rs2_used = 1'b0; #1;
        check("lu_rs2_unused", 32'(stall_id), 32'd0);
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; id_valid = 1'b0;

        // Scoreboard RAW / WAW on x7.
        tick();
        lop_issue = 1'b1; lop_issue_rd = 5'd7;
        tick();
        lop_issue = 1'b0;
        id_valid = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1; #1;
        check("sb_raw", 32'(stall_id), 32'd1);
        check("sb_out1", 32'(outstanding), 32'd1);
        id_rs1_used = 1'b0; id_rd = 5'd7; id_rd_used = 1'b1; #1;
        check("sb_waw", 32'(stall_id), 32'd1);
        lop_done = 1'b1; lop_done_rd = 5'd7;
        tick();
        lop_done = 1'b0; #1;
        check("sb_cleared", 32'(stall_id), 32'd0);
        check("sb_count", stall_cycles, 32'd2);
        check("sb_out0", 32'(outstanding), 32'd0);
        check("sb_no_err", 32'(sb_err), 32'd0);
        id_valid = 1'b0; id_rd_used = 1'b0;

        // Capacity: four issues fill the scoreboard.
        for (int i = 1; i <= 4; i++) begin
            lop_issue = 1'b1; lop_issue_rd = 5'(i);
            tick();
        end
        lop_issue = 1'b0; #1;
        check("cap_full", 32'(lop_full), 32'd1);
        check("cap_out4", 32'(outstanding), 32'd4);
        check("cap_stall", 32'(stall_id), 32'd1);
        lop_issue = 1'b1; lop_issue_rd = 5'd10; lop_done = 1'b1; lop_done_rd = 5'd1;
        tick();
        lop_issue = 1'b0; lop_done = 1'b0; #1;
        check("cap_swap_out", 32'(outstanding), 32'd4);
        check("cap_swap_err", 32'(sb_err), 32'd0);

        // Fifth issue while full with no done: ignored, error raised.
        lop_issue = 1'b1; lop_issue_rd = 5'd11;
        tick();
        lop_issue = 1'b0; #1;
        check("over_out", 32'(outstanding), 32'd4);
        check("over_err", 32'(sb_err), 32'd1);
        check("over_count", stall_cycles, 32'd4);
        tick();
        check("err_sticky", 32'(sb_err), 32'd1);

        // Reset mid-flight with hazards and forwarding inputs active.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd6;
        id_valid = 1'b1; id_rs1 = 5'd6; id_rs1_used = 1'b1;
        stage_wen = 2'b01; stage_rd = {5'd0, 5'd6}; ex_rs1 = 5'd6;
        rst = 1'b1; #1;
        check("mid_rst_stall", 32'(stall_id), 32'd0);
        check("mid_rst_fwdA", 32'(forwardA), 32'd0);
        check("mid_rst_out", 32'(outstanding), 32'd0);
        check("mid_rst_err", 32'(sb_err), 32'd0);
        tick();
        rst = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; stage_wen = 2'b00;
        id_rs1 = 5'd2; #1;
        check("post_rst_out", 32'(outstanding), 32'd0);
        check("post_rst_count", stall_cycles, 32'd0);
        check("post_rst_full", 32'(lop_full), 32'd0);
        check("post_rst_pending", 32'(stall_id), 32'd0);

        // Completion of a pre-reset op now counts as an error.
        id_valid = 1'b0;
        lop_done = 1'b1; lop_done_rd = 5'd3;
        tick();
        lop_done = 1'b0; #1;
        check("stale_done_err", 32'(sb_err), 32'd1);
        check("stale_done_out", 32'(outstanding), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
